// File: rtl/fighter_pkg.sv
// +--------------------------------------------------------------------+
// | fighter_pkg: attack type codes and attack FSM state encoding.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package fighter_pkg;

   // Attack type codes, also consumed by the animation state selector
   localparam logic [1:0] ATK_NONE  = 2'd0;
   localparam logic [1:0] ATK_LIGHT = 2'd1;
   localparam logic [1:0] ATK_HEAVY = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_STARTUP  = 3'd1,
      ST_ACTIVE   = 3'd2,
      ST_RECOVER  = 3'd3,
      ST_COOLDOWN = 3'd4
   } atk_state_t;

   function automatic int pick_len(input logic [1:0] atk_type, input int light_len,
                                   input int heavy_len);
      return (atk_type == ATK_LIGHT) ? light_len : heavy_len;
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_edge_latch.sv
// +--------------------------------------------------------------------+
// | btn_edge_latch: rising-edge detector with a pending flag held      |
// | until the next clear. Revision: 1.0                                |
// +--------------------------------------------------------------------+
`default_nettype none

module btn_edge_latch (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   input  logic clear,
   output logic pending
);

   logic r_prev;
   logic r_pend;
   logic w_rise;

   assign w_rise = btn & ~r_prev;

   // An edge arriving on the same clk as the clear is visible through
   // pending immediately, so the consuming tick sees it.
   assign pending = r_pend | w_rise;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev <= 1'b0;
         r_pend <= 1'b0;
      end else begin
         r_prev <= btn;
         if (clear)
            r_pend <= 1'b0;
         else if (w_rise)
            r_pend <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/player_attack_ctrl.sv
// +--------------------------------------------------------------------+
// | player_attack_ctrl: per-player attack sequencer stepping through   |
// | startup/active/recover/cooldown on SCEN. Revision: 1.0             |
// +--------------------------------------------------------------------+
`default_nettype none

module player_attack_ctrl
   import fighter_pkg::*;
#(
   parameter int ATK1_STARTUP = 4,
   parameter int ATK1_ACTIVE  = 3,
   parameter int ATK1_RECOVER = 6,
   parameter int ATK2_STARTUP = 8,
   parameter int ATK2_ACTIVE  = 4,
   parameter int ATK2_RECOVER = 12,
   parameter int COOLDOWN     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       SCEN,
   input  logic       btn_atk1,
   input  logic       btn_atk2,
   input  logic       hitstun_active,
   input  logic       jump_active,
   output logic       attack_active,
   output logic [1:0] attack_type,
   output logic [5:0] attack_frame,
   output logic       hitbox_active,
   output logic       attack_done
);

   localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

   logic            w_pend1;
   logic            w_pend2;
   atk_state_t      r_state;
   logic [5:0]      r_phase;
   logic [CD_W-1:0] r_cd;
   int              w_len;
   logic            w_phase_last;
   logic            w_cd_last;
   logic            w_start;

   btn_edge_latch u_latch_atk1 (
      .clk     (clk),
      .reset   (reset),
      .btn     (btn_atk1),
      .clear   (SCEN),
      .pending (w_pend1)
   );

   btn_edge_latch u_latch_atk2 (
      .clk     (clk),
      .reset   (reset),
      .btn     (btn_atk2),
      .clear   (SCEN),
      .pending (w_pend2)
   );

   always_comb begin
      w_len = 1;
      case (r_state)
         ST_STARTUP: w_len = pick_len(attack_type, ATK1_STARTUP, ATK2_STARTUP);
         ST_ACTIVE:  w_len = pick_len(attack_type, ATK1_ACTIVE, ATK2_ACTIVE);
         ST_RECOVER: w_len = pick_len(attack_type, ATK1_RECOVER, ATK2_RECOVER);
         default:    w_len = 1;
      endcase
   end

   assign w_phase_last = (r_phase == 6'(w_len - 1));
   assign w_cd_last    = (r_cd == CD_W'(COOLDOWN - 1));
   assign w_start      = (w_pend1 | w_pend2) & ~hitstun_active & ~jump_active;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_phase       <= 6'd0;
         r_cd          <= '0;
         attack_active <= 1'b0;
         attack_type   <= ATK_NONE;
         attack_frame  <= 6'd0;
         hitbox_active <= 1'b0;
         attack_done   <= 1'b0;
      end else begin
         attack_done <= 1'b0;
         if (SCEN) begin
            case (r_state)
               ST_IDLE: begin
                  if (w_start) begin
                     r_state       <= ST_STARTUP;
                     r_phase       <= 6'd0;
                     attack_active <= 1'b1;
                     attack_type   <= w_pend1 ? ATK_LIGHT : ATK_HEAVY;
                     attack_frame  <= 6'd0;
                  end
               end
               ST_STARTUP, ST_ACTIVE, ST_RECOVER: begin
                  if (hitstun_active) begin
                     r_state       <= ST_IDLE;
                     r_phase       <= 6'd0;
                     attack_active <= 1'b0;
                     attack_type   <= ATK_NONE;
                     attack_frame  <= 6'd0;
                     hitbox_active <= 1'b0;
                  end else if (!w_phase_last) begin
                     r_phase      <= r_phase + 6'd1;
                     attack_frame <= attack_frame + 6'd1;
                  end else begin
                     r_phase      <= 6'd0;
                     attack_frame <= attack_frame + 6'd1;
                     case (r_state)
                        ST_STARTUP: begin
                           r_state       <= ST_ACTIVE;
                           hitbox_active <= 1'b1;
                        end
                        ST_ACTIVE: begin
                           r_state       <= ST_RECOVER;
                           hitbox_active <= 1'b0;
                        end
                        default: begin
                           // Normal completion: clear everything and pulse done
                           attack_active <= 1'b0;
                           attack_type   <= ATK_NONE;
                           attack_frame  <= 6'd0;
                           hitbox_active <= 1'b0;
                           attack_done   <= 1'b1;
                           r_cd          <= '0;
                           r_state       <= (COOLDOWN == 0) ? ST_IDLE : ST_COOLDOWN;
                        end
                     endcase
                  end
               end
               ST_COOLDOWN: begin
                  if (w_cd_last) begin
                     r_state <= ST_IDLE;
                     r_cd    <= '0;
                  end else begin
                     r_cd <= r_cd + 1'b1;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_player_attack_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_player_attack_ctrl: directed and random stimulus against a      |
// | frame-count reference model. Revision: 1.0                         |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_player_attack_ctrl;

   localparam int S1 = 4, A1 = 3, R1 = 6;
   localparam int S2 = 8, A2 = 4, R2 = 12;
   localparam int CD = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       SCEN = 1'b0;
   logic       btn_atk1 = 1'b0;
   logic       btn_atk2 = 1'b0;
   logic       hitstun_active = 1'b0;
   logic       jump_active = 1'b0;
   logic       attack_active;
   logic [1:0] attack_type;
   logic [5:0] attack_frame;
   logic       hitbox_active;
   logic       attack_done;

   player_attack_ctrl #(
      .ATK1_STARTUP (S1), .ATK1_ACTIVE (A1), .ATK1_RECOVER (R1),
      .ATK2_STARTUP (S2), .ATK2_ACTIVE (A2), .ATK2_RECOVER (R2),
      .COOLDOWN     (CD)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .SCEN           (SCEN),
      .btn_atk1       (btn_atk1),
      .btn_atk2       (btn_atk2),
      .hitstun_active (hitstun_active),
      .jump_active    (jump_active),
      .attack_active  (attack_active),
      .attack_type    (attack_type),
      .attack_frame   (attack_frame),
      .hitbox_active  (hitbox_active),
      .attack_done    (attack_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit rand_mode = 0;

   // Reference model: mode 0 idle, 1 attacking (m_k = frames elapsed), 2 cooldown
   int m_mode, m_typ, m_k, m_cdk;
   bit m_prev1, m_prev2, m_pend1, m_pend2, m_done;
   int done_count = 0;
   int hb_min, hb_max;

   function automatic int total_len(input int t);
      return (t == 1) ? (S1 + A1 + R1) : (S2 + A2 + R2);
   endfunction

   function automatic int startup_len(input int t);
      return (t == 1) ? S1 : S2;
   endfunction

   function automatic int active_len(input int t);
      return (t == 1) ? A1 : A2;
   endfunction

   task automatic m_reset();
      m_mode = 0; m_typ = 0; m_k = 0; m_cdk = 0;
      m_prev1 = 0; m_prev2 = 0; m_pend1 = 0; m_pend2 = 0; m_done = 0;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic model_update();
      bit e1, e2, r1, r2;
      if (reset) begin
         m_reset();
         return;
      end
      e1 = btn_atk1 && !m_prev1;
      e2 = btn_atk2 && !m_prev2;
      r1 = m_pend1 || e1;
      r2 = m_pend2 || e2;
      m_prev1 = btn_atk1;
      m_prev2 = btn_atk2;
      m_done = 0;
      if (SCEN) begin
         case (m_mode)
            0: if ((r1 || r2) && !hitstun_active && !jump_active) begin
                  m_mode = 1; m_typ = r1 ? 1 : 2; m_k = 0;
               end
            1: if (hitstun_active) begin
                  m_mode = 0;
               end else if (m_k == total_len(m_typ) - 1) begin
                  m_done = 1;
                  m_cdk = 0;
                  m_mode = (CD > 0) ? 2 : 0;
               end else begin
                  m_k++;
               end
            default: begin
               m_cdk++;
               if (m_cdk == CD) m_mode = 0;
            end
         endcase
         m_pend1 = 0;
         m_pend2 = 0;
      end else begin
         m_pend1 = r1;
         m_pend2 = r2;
      end
      if (m_done) done_count++;
   endtask

   task automatic check_outputs();
      bit act, hb;
      act = (m_mode == 1);
      hb  = act && (m_k >= startup_len(m_typ)) && (m_k < startup_len(m_typ) + active_len(m_typ));
      chk("attack_active", 8'(attack_active), 8'(act));
      chk("attack_type",   8'(attack_type),   act ? 8'(m_typ) : 8'd0);
      chk("attack_frame",  8'(attack_frame),  act ? 8'(m_k) : 8'd0);
      chk("hitbox_active", 8'(hitbox_active), 8'(hb));
      chk("attack_done",   8'(attack_done),   8'(m_done));
      if (hitbox_active === 1'b1) begin
         if (int'(attack_frame) < hb_min) hb_min = int'(attack_frame);
         if (int'(attack_frame) > hb_max) hb_max = int'(attack_frame);
      end
   endtask

   task automatic clk_cycle();
      cyc++;
      if (rand_mode) SCEN = ($urandom_range(0, 2) == 0);
      else           SCEN = ((cyc % 4) == 0);
      @(posedge clk);
      model_update();
      #1;
      check_outputs();
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < 4 * n; i++) clk_cycle();
   endtask

   task automatic press(input bit b1, input bit b2);
      btn_atk1 = b1;
      btn_atk2 = b2;
      clk_cycle();
      btn_atk1 = 1'b0;
      btn_atk2 = 1'b0;
   endtask

   task automatic wait_model(input int want_mode, input int want_k, input string tag);
      int n;
      n = 0;
      while (!(m_mode == want_mode && (want_k < 0 || m_k == want_k)) && n < 400) begin
         clk_cycle();
         n++;
      end
      if (n >= 400) begin
         tests++;
         fails++;
         $error("FAIL %s timeout observed=%0d expected=%0d", tag, m_mode, want_mode);
      end
   endtask

   initial begin
      int d0;
      m_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) clk_cycle();
      reset = 1'b0;
      run_ticks(2);

      // Light attack: frames 0..12, hitbox on 4..6, one done pulse
      hb_min = 99; hb_max = -1;
      d0 = done_count;
      press(1, 0);
      run_ticks(16);
      chk("light_done_pulses", 8'(done_count - d0), 8'd1);
      chk("light_hitbox_first", 8'(hb_min), 8'd4);
      chk("light_hitbox_last",  8'(hb_max), 8'd6);

      // Cooldown discard, then a press once cooldown has elapsed
      press(1, 0);
      wait_model(2, -1, "cooldown_enter");
      run_ticks(2);
      press(1, 0);
      wait_model(0, -1, "cooldown_exit");
      press(1, 0);
      run_ticks(20);

      // Simultaneous press: light wins; then heavy alone
      press(1, 1);
      run_ticks(20);
      hb_min = 99; hb_max = -1;
      d0 = done_count;
      press(0, 1);
      run_ticks(30);
      chk("heavy_done_pulses", 8'(done_count - d0), 8'd1);
      chk("heavy_hitbox_first", 8'(hb_min), 8'd8);
      chk("heavy_hitbox_last",  8'(hb_max), 8'd11);

      // Abort heavy at frame 9: no done, no cooldown, immediate restart
      d0 = done_count;
      press(0, 1);
      wait_model(1, 9, "abort_reach_frame9");
      hitstun_active = 1'b1;
      run_ticks(1);
      hitstun_active = 1'b0;
      chk("abort_no_done", 8'(done_count - d0), 8'd0);
      chk("abort_active_low", 8'(attack_active), 8'd0);
      while (!((cyc + 1) % 4 == 0)) clk_cycle();
      press(1, 0);
      chk("abort_restart_type", 8'(attack_type), 8'd1);
      run_ticks(20);

      // Blocking by jump and hitstun; request must not survive
      jump_active = 1'b1;
      press(1, 0);
      run_ticks(3);
      jump_active = 1'b0;
      run_ticks(3);
      chk("jump_block", 8'(attack_active), 8'd0);
      hitstun_active = 1'b1;
      press(0, 1);
      run_ticks(3);
      hitstun_active = 1'b0;
      run_ticks(3);
      chk("hitstun_block", 8'(attack_active), 8'd0);

      // Holding the button across attack and cooldown: exactly one attack
      d0 = done_count;
      btn_atk1 = 1'b1;
      run_ticks(40);
      btn_atk1 = 1'b0;
      run_ticks(2);
      chk("hold_one_attack", 8'(done_count - d0), 8'd1);

      // Asynchronous reset between ticks while in ACTIVE
      press(0, 1);
      wait_model(1, 9, "rst_reach_active");
      #2 reset = 1'b1;
      #1;
      chk("async_rst_active", 8'(attack_active), 8'd0);
      chk("async_rst_type",   8'(attack_type),   8'd0);
      chk("async_rst_frame",  8'(attack_frame),  8'd0);
      chk("async_rst_hitbox", 8'(hitbox_active), 8'd0);
      m_reset();
      clk_cycle();
      clk_cycle();
      reset = 1'b0;
      run_ticks(3);

      // Random traffic
      rand_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) btn_atk1 = ~btn_atk1;
         if ($urandom_range(0, 9) == 0) btn_atk2 = ~btn_atk2;
         hitstun_active = ($urandom_range(0, 39) == 0);
         jump_active    = ($urandom_range(0, 19) == 0);
         clk_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
